tile_scheduler: RTL and testbench

- Layer-level sequencer above the weight controller. Walks a layer as a 2-D loop of output-channel tiles (outer) × input-channel tiles (inner).
- Per tile: starts the weight controller, waits for the array to finish the tile, then controls accumulator clear and output drain.
- Sits between the host/config registers and the weight controller, systolic array accumulators and output writer.

---
 rtl/accel_pkg.sv | 20 ++
 rtl/tile_scheduler_counter.sv | 52 +++++
 rtl/tile_scheduler.sv | 166 ++++++++++++++++
 tb/tb_tile_scheduler.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/accel_pkg.sv
// Shared accelerator definitions.
//   CNT_W_DEF   : default width of tile counts and tile indices
//   tile_idx_t  : tile index type, shared with the address generators
//   ts_state_e  : tile_scheduler sequencing states
package accel_pkg;

    localparam int CNT_W_DEF = 12;

    typedef logic [CNT_W_DEF-1:0] tile_idx_t;

    typedef enum logic [2:0] {
        TS_IDLE,
        TS_ISSUE,
        TS_WAIT_ACK,
        TS_RUN,
        TS_DRAIN,
        TS_FINISH
    } ts_state_e;

endpackage

// File: rtl/tile_scheduler_counter.sv
// tile_counter: two-level nested tile index counter.
// The inner index walks input-channel tiles and the outer index walks
// output-channel tiles.
//   clk, rst    : clock, synchronous active-high reset
//   clear       : zero both indices (start of a layer)
//   inc_inner   : advance the inner index
//   next_outer  : zero the inner index and advance the outer index, unless
//                 the outer index is already on its last tile
//   num_inner   : inner tile count (latched by the owner)
//   num_outer   : outer tile count (latched by the owner)
//   idx_inner   : registered inner index
//   idx_outer   : registered outer index
//   last_inner  : idx_inner is the final inner tile
//   last_outer  : idx_outer is the final outer tile
module tile_counter
    import accel_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             inc_inner,
    input  logic             next_outer,
    input  logic [CNT_W-1:0] num_inner,
    input  logic [CNT_W-1:0] num_outer,
    output logic [CNT_W-1:0] idx_inner,
    output logic [CNT_W-1:0] idx_outer,
    output logic             last_inner,
    output logic             last_outer
);

    // Counts are at least 1 whenever these flags are consulted, so the
    // minus-one never wraps in use.
    assign last_inner = (idx_inner == num_inner - 1'b1);
    assign last_outer = (idx_outer == num_outer - 1'b1);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            idx_inner <= '0;
            idx_outer <= '0;
        end else if (next_outer) begin
            idx_inner <= '0;
            // The final outer index is held so it stays visible after the layer.
            if (!last_outer)
                idx_outer <= idx_outer + 1'b1;
        end else if (inc_inner) begin
            idx_inner <= idx_inner + 1'b1;
        end
    end

endmodule

// File: rtl/tile_scheduler.sv
// tile_scheduler: layer-level sequencer above the weight controller.
// Walks a layer as output-channel tiles (outer) x input-channel tiles
// (inner). For each tile it starts the weight controller, waits for the
// array to finish the tile, and after the last input-channel tile of an
// output-channel tile it asks the output writer to drain the accumulators.
//   clk, rst    : clock, synchronous active-high reset
//   layer_start : pulse, latch num_oc/num_ic and start a layer (idle only)
//   num_oc      : output-channel tile count
//   num_ic      : input-channel tile count
//   wc_ready    : weight controller can accept a start
//   wc_start    : one-cycle start pulse to the weight controller
//   tile_done   : pulse, array finished the current tile
//   acc_clr     : accumulators overwrite instead of add for this tile
//   drain_req   : level, request an accumulator drain
//   drain_done  : pulse, drain complete
//   oc_idx      : current output-channel tile index
//   ic_idx      : current input-channel tile index
//   busy        : layer in progress
//   layer_done  : one-cycle pulse at end of layer
//   err         : sticky ack-timeout flag, cleared by rst or layer_start
module tile_scheduler
    import accel_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             layer_start,
    input  logic [CNT_W-1:0] num_oc,
    input  logic [CNT_W-1:0] num_ic,
    input  logic             wc_ready,
    output logic             wc_start,
    input  logic             tile_done,
    output logic             acc_clr,
    output logic             drain_req,
    input  logic             drain_done,
    output logic [CNT_W-1:0] oc_idx,
    output logic [CNT_W-1:0] ic_idx,
    output logic             busy,
    output logic             layer_done,
    output logic             err
);

    // Wide enough to count up to ACK_TIMEOUT-1; one bit when the check is off.
    localparam int AW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;

    ts_state_e        state;
    logic [CNT_W-1:0] cnt_oc;
    logic [CNT_W-1:0] cnt_ic;
    logic [AW-1:0]    ack_cnt;

    logic ctr_clear;
    logic ctr_inc_inner;
    logic ctr_next_outer;
    logic last_inner;
    logic last_outer;

    // Index moves are decoded from the same conditions the FSM acts on, so
    // the indices update on the same edge as the state change.
    always_comb begin
        ctr_clear      = (state == TS_IDLE) && layer_start;
        ctr_inc_inner  = (state == TS_RUN) && tile_done && !last_inner;
        ctr_next_outer = (state == TS_DRAIN) && drain_done;
    end

    tile_counter #(
        .CNT_W (CNT_W)
    ) u_tile_counter (
        .clk        (clk),
        .rst        (rst),
        .clear      (ctr_clear),
        .inc_inner  (ctr_inc_inner),
        .next_outer (ctr_next_outer),
        .num_inner  (cnt_ic),
        .num_outer  (cnt_oc),
        .idx_inner  (ic_idx),
        .idx_outer  (oc_idx),
        .last_inner (last_inner),
        .last_outer (last_outer)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= TS_IDLE;
            wc_start   <= 1'b0;
            acc_clr    <= 1'b0;
            drain_req  <= 1'b0;
            busy       <= 1'b0;
            layer_done <= 1'b0;
            err        <= 1'b0;
            cnt_oc     <= '0;
            cnt_ic     <= '0;
            ack_cnt    <= '0;
        end else begin
            wc_start   <= 1'b0;
            layer_done <= 1'b0;
            case (state)
                TS_IDLE: begin
                    if (layer_start) begin
                        cnt_oc <= num_oc;
                        cnt_ic <= num_ic;
                        err    <= 1'b0;
                        // An empty layer still reports completion.
                        if (num_oc == '0 || num_ic == '0) begin
                            state <= TS_FINISH;
                        end else begin
                            busy  <= 1'b1;
                            state <= TS_ISSUE;
                        end
                    end
                end
                TS_ISSUE: begin
                    if (wc_ready) begin
                        wc_start <= 1'b1;
                        // First input-channel tile overwrites, the rest accumulate.
                        acc_clr  <= (ic_idx == '0);
                        ack_cnt  <= '0;
                        state    <= TS_WAIT_ACK;
                    end
                end
                TS_WAIT_ACK: begin
                    // The controller acknowledges by dropping ready.
                    if (!wc_ready) begin
                        state <= TS_RUN;
                    end else if (ACK_TIMEOUT != 0 &&
                                 ack_cnt == AW'(ACK_TIMEOUT - 1)) begin
                        err     <= 1'b1;
                        busy    <= 1'b0;
                        acc_clr <= 1'b0;
                        state   <= TS_IDLE;
                    end else begin
                        ack_cnt <= ack_cnt + 1'b1;
                    end
                end
                TS_RUN: begin
                    if (tile_done) begin
                        acc_clr <= 1'b0;
                        if (last_inner) begin
                            drain_req <= 1'b1;
                            state     <= TS_DRAIN;
                        end else begin
                            state <= TS_ISSUE;
                        end
                    end
                end
                TS_DRAIN: begin
                    if (drain_done) begin
                        drain_req <= 1'b0;
                        if (last_outer)
                            state <= TS_FINISH;
                        else
                            state <= TS_ISSUE;
                    end
                end
                TS_FINISH: begin
                    layer_done <= 1'b1;
                    busy       <= 1'b0;
                    state      <= TS_IDLE;
                end
                default: state <= TS_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tile_scheduler.sv
// Bench for tile_scheduler: reactive controller/array/writer models drive
// the DUT, a tile-list model predicts every output each cycle, and directed
// scenarios add hand-computed expectations.
module tb_tile_scheduler;

    localparam int CW = 12;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          layer_start = 1'b0;
    logic [CW-1:0] num_oc = '0;
    logic [CW-1:0] num_ic = '0;
    logic          wc_ready = 1'b1;
    logic          tile_done = 1'b0;
    logic          drain_done = 1'b0;
    logic          wc_start, acc_clr, drain_req, busy, layer_done, err;
    logic [CW-1:0] oc_idx, ic_idx;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    tile_scheduler #(.CNT_W(CW), .ACK_TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .layer_start(layer_start),
        .num_oc     (num_oc),
        .num_ic     (num_ic),
        .wc_ready   (wc_ready),
        .wc_start   (wc_start),
        .tile_done  (tile_done),
        .acc_clr    (acc_clr),
        .drain_req  (drain_req),
        .drain_done (drain_done),
        .oc_idx     (oc_idx),
        .ic_idx     (ic_idx),
        .busy       (busy),
        .layer_done (layer_done),
        .err        (err)
    );

    task chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", name, act, want, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // The layer is a flat list of tiles t = oc*num_ic + ic; the model tracks
    // which handshake it is waiting on and derives indices from t.
    localparam int M_IDLE = 0, M_REQ = 1, M_ACK = 2, M_TILE = 3, M_DRN = 4, M_FIN = 5;

    logic          s_rst, s_ls, s_rdy, s_td, s_dd;
    logic [CW-1:0] s_noc, s_nic;
    bit            started = 0;

    always @(posedge clk) begin
        s_rst   <= rst;
        s_ls    <= layer_start;
        s_rdy   <= wc_ready;
        s_td    <= tile_done;
        s_dd    <= drain_done;
        s_noc   <= num_oc;
        s_nic   <= num_ic;
        started <= 1'b1;
    end

    int m_mode = M_IDLE, lat_oc = 0, lat_ic = 0, t = 0, m_ack = 0;
    int e_wcs = 0, e_acc = 0, e_drq = 0, e_busy = 0, e_ld = 0, e_err = 0, e_oc = 0, e_ic = 0;

    task model_step();
        e_wcs = 0;
        e_ld  = 0;
        if (s_rst) begin
            m_mode = M_IDLE; lat_oc = 0; lat_ic = 0; t = 0;
            e_acc = 0; e_drq = 0; e_busy = 0; e_err = 0; e_oc = 0; e_ic = 0;
        end else begin
            case (m_mode)
                M_IDLE: if (s_ls) begin
                    lat_oc = int'(s_noc); lat_ic = int'(s_nic);
                    e_err = 0; t = 0; e_oc = 0; e_ic = 0;
                    if (lat_oc == 0 || lat_ic == 0) m_mode = M_FIN;
                    else begin m_mode = M_REQ; e_busy = 1; end
                end
                M_REQ: if (s_rdy) begin
                    e_wcs = 1; e_acc = (t % lat_ic == 0); m_ack = 0; m_mode = M_ACK;
                end
                M_ACK: if (!s_rdy) m_mode = M_TILE;
                else begin
                    m_ack++;
                    if (m_ack >= TO) begin
                        e_err = 1; e_busy = 0; e_acc = 0; m_mode = M_IDLE;
                    end
                end
                M_TILE: if (s_td) begin
                    e_acc = 0;
                    if (t % lat_ic == lat_ic - 1) begin e_drq = 1; m_mode = M_DRN; end
                    else begin t++; m_mode = M_REQ; end
                end
                M_DRN: if (s_dd) begin
                    e_drq = 0; t++;
                    if (t == lat_oc * lat_ic) begin
                        m_mode = M_FIN; e_oc = lat_oc - 1; e_ic = 0;
                    end else m_mode = M_REQ;
                end
                M_FIN: begin e_ld = 1; e_busy = 0; m_mode = M_IDLE; end
                default: m_mode = M_IDLE;
            endcase
            if (m_mode >= M_REQ && m_mode <= M_DRN) begin
                e_oc = t / lat_ic;
                e_ic = t % lat_ic;
            end
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            model_step();
            chk("wc_start", wc_start, e_wcs);
            chk("acc_clr", acc_clr, e_acc);
            chk("drain_req", drain_req, e_drq);
            chk("busy", busy, e_busy);
            chk("layer_done", layer_done, e_ld);
            chk("err", err, e_err);
            chk("oc_idx", oc_idx, e_oc);
            chk("ic_idx", ic_idx, e_ic);
        end
    end

    // ---------------- environment ----------------
    int rdy_len = 1, rdy_cnt = 0, tmin = 10, tmax = 10, tile_cnt = 0, dr_cnt = 0;
    bit stuck = 0, spur = 0, dr_armed = 0;
    logic rdy_prev;
    int start_low = 0;

    task env_update();
        layer_start = 1'b0;
        tile_done   = 1'b0;
        drain_done  = 1'b0;
        if (tile_cnt > 0) begin
            tile_cnt--;
            if (tile_cnt == 0) tile_done = 1'b1;
        end
        if (wc_start && !stuck) begin
            wc_ready = 1'b0;
            rdy_cnt  = rdy_len;
            tile_cnt = $urandom_range(tmax, tmin);
        end else if (!wc_ready) begin
            if (rdy_cnt > 1) rdy_cnt--;
            else wc_ready = 1'b1;
        end
        if (drain_req && !dr_armed) begin
            dr_armed = 1; dr_cnt = $urandom_range(5, 1);
        end else if (dr_armed && dr_cnt > 0) begin
            dr_cnt--;
            if (dr_cnt == 0) drain_done = 1'b1;
        end else if (dr_armed && !drain_req) dr_armed = 0;
        if (spur && $urandom_range(3, 0) == 0) begin
            if (drain_req) tile_done = 1'b1;
            else if (tile_cnt > 1) drain_done = 1'b1;
            else if (busy && wc_ready && tile_cnt == 0 && !wc_start) tile_done = 1'b1;
            if (busy) begin
                layer_start = 1'b1;
                num_oc = CW'($urandom_range(5, 0));
                num_ic = CW'($urandom_range(5, 0));
            end
        end
    endtask

    task tick();
        @(negedge clk);
        rdy_prev = wc_ready;
        env_update();
    endtask

    task automatic run_layer(input int noc, input int nic, output int n_st, output int n_clr,
                             output int n_drq, output int n_ld, output bit busy_ok);
        bit prev_drq = 0;
        bit end_ok = 0;
        n_st = 0; n_clr = 0; n_drq = 0; n_ld = 0; busy_ok = 1;
        tick();
        layer_start = 1'b1;
        num_oc = CW'(noc);
        num_ic = CW'(nic);
        wc_ready = 1'b0;
        rdy_cnt = rdy_len;
        for (int c = 0; c < 4000; c++) begin
            tick();
            if (wc_start) begin
                n_st++;
                if (acc_clr) n_clr++;
                if (!rdy_prev) start_low++;
            end
            if (drain_req && !prev_drq) n_drq++;
            prev_drq = drain_req;
            if (layer_done) begin n_ld++; end_ok = 1; break; end
            if (!busy) busy_ok = 0;
            if (err) break;
        end
        chk("layer_end", end_ok, 1);
    endtask

    task wait_done();
        bit ok = 0;
        for (int c = 0; c < 4000; c++) begin
            tick();
            if (layer_done) begin ok = 1; break; end
        end
        chk("wait_done", ok, 1);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish at %0t", $time);
        $fatal(1);
    end

    // ---------------- directed + random scenarios ----------------
    initial begin
        int n_st, n_clr, n_drq, n_ld, n;
        bit bok, got, saw_ld;

        repeat (3) tick();
        chk("reset_busy", busy, 0);
        chk("reset_idx", {oc_idx, ic_idx}, 0);
        chk("reset_outs", {wc_start, acc_clr, drain_req, layer_done, err}, 0);
        rst = 1'b0;
        tick();

        // 2x3 layer, ready drops right after start, tiles take 10 cycles
        rdy_len = 1; tmin = 10; tmax = 10;
        run_layer(2, 3, n_st, n_clr, n_drq, n_ld, bok);
        chk("l23_starts", n_st, 6);
        chk("l23_clr_starts", n_clr, 2);
        chk("l23_drains", n_drq, 2);
        chk("l23_done", n_ld, 1);
        chk("l23_busy_held", bok, 1);
        chk("l23_final_oc", oc_idx, 1);
        chk("l23_final_ic", ic_idx, 0);
        tick();
        chk("l23_done_one_cycle", layer_done, 0);
        chk("l23_busy_low", busy, 0);

        // zero-count layers finish two cycles after the start pulse
        tick(); layer_start = 1'b1; num_oc = 0; num_ic = 3;
        tick(); chk("zoc_ld_c1", layer_done, 0); chk("zoc_no_start", wc_start, 0);
        tick(); chk("zoc_ld_c2", layer_done, 1);
        tick(); layer_start = 1'b1; num_oc = 4; num_ic = 0;
        tick(); chk("zic_ld_c1", layer_done, 0); chk("zic_no_start", wc_start, 0);
        tick(); chk("zic_ld_c2", layer_done, 1);

        // ready held low for 20 cycles before every tile
        rdy_len = 20; tmin = 3; tmax = 6; start_low = 0;
        run_layer(2, 2, n_st, n_clr, n_drq, n_ld, bok);
        chk("slow_starts", n_st, 4);
        chk("slow_start_while_low", start_low, 0);

        // ack timeout: ready never drops after the start
        rdy_len = 2; stuck = 1;
        tick(); layer_start = 1'b1; num_oc = 1; num_ic = 1;
        got = 0;
        for (int c = 0; c < 50; c++) begin
            tick();
            if (wc_start) begin got = 1; break; end
        end
        chk("to_start_seen", got, 1);
        n = 0; saw_ld = 0;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (layer_done) saw_ld = 1;
            if (err) begin n = c; break; end
        end
        chk("to_latency", n, 4);
        chk("to_busy", busy, 0);
        chk("to_no_done", saw_ld, 0);
        stuck = 0;
        tick(); layer_start = 1'b1; num_oc = 1; num_ic = 1;
        tick(); chk("err_cleared", err, 0);
        wait_done();

        // spurious pulses and a second layer_start mid-layer
        spur = 1; rdy_len = 3; tmin = 4; tmax = 8;
        run_layer(2, 2, n_st, n_clr, n_drq, n_ld, bok);
        chk("spur_starts", n_st, 4);
        chk("spur_done", n_ld, 1);
        spur = 0;

        // reset during the second drain of a 3x2 layer
        rdy_len = 1; tmin = 3; tmax = 5;
        tick(); layer_start = 1'b1; num_oc = 3; num_ic = 2;
        got = 0;
        for (int c = 0; c < 2000; c++) begin
            tick();
            if (drain_req && oc_idx == 1) begin got = 1; break; end
        end
        chk("rst_reach_drain", got, 1);
        rst = 1'b1;
        tick();
        chk("rst_outs", {wc_start, acc_clr, drain_req, busy, layer_done, err}, 0);
        chk("rst_idx", {oc_idx, ic_idx}, 0);
        rst = 1'b0;
        wc_ready = 1'b1; rdy_cnt = 0; tile_cnt = 0; dr_armed = 0; dr_cnt = 0;
        tile_done = 1'b0; drain_done = 1'b0;
        run_layer(1, 3, n_st, n_clr, n_drq, n_ld, bok);
        chk("post_rst_starts", n_st, 3);
        chk("post_rst_clr", n_clr, 1);
        chk("post_rst_done", n_ld, 1);

        // random layers
        for (int i = 0; i < 12; i++) begin
            int noc, nic;
            noc = $urandom_range(3, 0);
            nic = $urandom_range(3, 0);
            rdy_len = $urandom_range(4, 1);
            tmin = 2; tmax = $urandom_range(9, 2);
            spur = ($urandom_range(1, 0) == 1);
            run_layer(noc, nic, n_st, n_clr, n_drq, n_ld, bok);
            chk("rnd_starts", n_st, noc * nic);
            chk("rnd_drains", n_drq, (nic == 0) ? 0 : noc);
            chk("rnd_done", n_ld, 1);
        end
        spur = 0;
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
